// File: rtl/mem_stage_ctrl_if.sv
// MEM-stage controller bus: pipeline request/response plus line-wide memory port.
// The controller sits on the slave modport; the pipeline/memory model drives master.
interface mem_stage_ctrl_if #(
   parameter int ADDR_W     = 16,
   parameter int LINE_BYTES = 16,
   parameter int OFF_W      = $clog2(LINE_BYTES)
);
   logic                      req_read;
   logic                      req_write;
   logic                      req_indirect;
   logic                      req_byte;
   logic [ADDR_W-1:0]         req_addr;
   logic [15:0]               req_wdata;
   logic                      mem_resp;
   logic [LINE_BYTES*8-1:0]   mem_rdata;
   logic                      mem_read;
   logic                      mem_write;
   logic [ADDR_W-OFF_W-1:0]   mem_address;
   logic [LINE_BYTES*8-1:0]   mem_wdata;
   logic [LINE_BYTES-1:0]     mem_sel;
   logic [15:0]               rdata;
   logic                      stall;
   logic                      done;
   logic                      timeout_err;

   modport slave (
      input  req_read, req_write, req_indirect, req_byte, req_addr, req_wdata,
             mem_resp, mem_rdata,
      output mem_read, mem_write, mem_address, mem_wdata, mem_sel,
             rdata, stall, done, timeout_err
   );

   modport master (
      output req_read, req_write, req_indirect, req_byte, req_addr, req_wdata,
             mem_resp, mem_rdata,
      input  mem_read, mem_write, mem_address, mem_wdata, mem_sel,
             rdata, stall, done, timeout_err
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage load/store controller with pointer-chasing LDI/STI over a line-wide memory port.
// Optional watchdog enabled by defining MEM_STAGE_CTRL_TIMEOUT_EN.
module mem_stage_ctrl #(
   parameter int ADDR_W         = 16,
   parameter int LINE_BYTES     = 16,
   parameter int OFF_W          = $clog2(LINE_BYTES),
   parameter int IND_DEPTH      = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic           clk,
   input  logic           reset,
   mem_stage_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, IND, ACCESS} state_t;

   state_t            state;
   logic [1:0]        lvl;
   logic [ADDR_W-1:0] ptr;

   logic              req_valid, in_ind, in_acc, outstanding;
   logic [ADDR_W-1:0] cur_addr;
   logic [OFF_W-1:0]  off, widx;
   logic [15:0]       word_rd, wr_word;
   logic [7:0]        byte_rd;

   assign req_valid = bus.req_read | bus.req_write;
   // Pointer phase starts straight from IDLE so the first read goes out without a bubble.
   assign in_ind = req_valid && bus.req_indirect && (state == IDLE || state == IND);
   assign in_acc = req_valid && (state == ACCESS || (state == IDLE && !bus.req_indirect));
   assign outstanding = in_ind | in_acc;

   always_comb begin
      cur_addr = bus.req_addr;
      if (state == ACCESS && bus.req_indirect)
         cur_addr = ptr;
      else if (state == IND && lvl != 2'd0)
         cur_addr = ptr;
   end

   assign off  = cur_addr[OFF_W-1:0];
   assign widx = off >> 1;

   always_comb begin
      word_rd = '0;
      for (int i = 0; i < LINE_BYTES/2; i++)
         if (widx == OFF_W'(i))
            word_rd = bus.mem_rdata[i*16 +: 16];
   end

   assign byte_rd = off[0] ? word_rd[15:8] : word_rd[7:0];
   assign wr_word = bus.req_byte ? {2{bus.req_wdata[7:0]}} : bus.req_wdata;

   always_comb begin
      bus.mem_sel = '0;
      for (int i = 0; i < LINE_BYTES; i++)
         bus.mem_sel[i] = (in_acc && bus.req_byte) ? (off == OFF_W'(i))
                                                   : (widx == OFF_W'(i/2));
   end

   assign bus.mem_address = cur_addr[ADDR_W-1:OFF_W];
   assign bus.mem_wdata   = {(LINE_BYTES/2){wr_word}};
   assign bus.rdata       = bus.req_byte ? {8'h00, byte_rd} : word_rd;
   // Store wins over load when both are raised.
   assign bus.mem_read    = !reset && (in_ind || (in_acc && !bus.req_write));
   assign bus.mem_write   = !reset && in_acc && bus.req_write;
   assign bus.done        = !reset && in_acc && bus.mem_resp;
   assign bus.stall       = !reset && req_valid && !(in_acc && bus.mem_resp);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         lvl   <= 2'd0;
         ptr   <= '0;
      end else if (in_ind && bus.mem_resp) begin
         ptr <= ADDR_W'({word_rd[15:1], 1'b0});
         if (lvl == 2'(IND_DEPTH-1)) begin
            state <= ACCESS;
         end else begin
            lvl   <= lvl + 2'd1;
            state <= IND;
         end
      end else if (in_ind) begin
         state <= IND;
      end else if (in_acc && bus.mem_resp) begin
         state <= IDLE;
         lvl   <= 2'd0;
      end else if (in_acc) begin
         state <= ACCESS;
      end else if (!req_valid) begin
         state <= IDLE;
         lvl   <= 2'd0;
      end
   end

`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;
   logic            to_err;

   // Counts back-to-back unanswered cycles across all phases; any mem_resp rearms it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
         to_err <= 1'b0;
      end else if (outstanding && !bus.mem_resp) begin
         if (to_cnt != TO_W'(TIMEOUT_CYCLES))
            to_cnt <= to_cnt + 1'b1;
         if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1))
            to_err <= 1'b1;
      end else begin
         to_cnt <= '0;
      end
   end

   assign bus.timeout_err = to_err;
`else
   assign bus.timeout_err = 1'b0;
`endif
endmodule
